key_expansion: RTL and testbench



---
 rtl/aes_pkg.sv | 55 +++++
 rtl/key_expansion.sv | 103 ++++++++++
 tb/tb_key_expansion.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES shared primitives: byte/word types, S-box, and the word-level helpers
// used by both the key schedule and the cipher rounds.
package aes_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic word_t sub_word(word_t x);
      return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
   endfunction

   function automatic word_t rot_word(word_t x);
      return {x[23:0], x[31:24]};
   endfunction

   function automatic byte_t xtime(byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/key_expansion.sv
// AES key schedule: expands an Nk-word cipher key into 4*Nr+4 words,
// one word per clock, into a flat MSB-first round-key vector.
module key_expansion
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [0:32*Nk-1]          key,
   output logic [0:32*(4*Nr+4)-1]    w,
   output logic                      done
);

   localparam int NW = 4 * Nr + 4;
   localparam int IW = $clog2(NW);

   if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_cfg
      $error("key_expansion: illegal Nk/Nr combination");
   end

   word_t          w_q [NW];
   word_t          w_d [NW];
   logic [IW-1:0]  idx_q, idx_d;
   logic [2:0]     phase_q, phase_d;
   byte_t          rcon_q, rcon_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   word_t          prev_w;
   word_t          back_w;
   word_t          t_w;

   always_comb begin
      w_d     = w_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      rcon_d  = rcon_q;
      busy_d  = busy_q;
      done_d  = done_q;
      prev_w  = w_q[idx_q - IW'(1)];
      back_w  = w_q[idx_q - IW'(Nk)];
      t_w     = prev_w;

      if (phase_q == 3'd0) begin
         t_w = sub_word(rot_word(prev_w)) ^ {rcon_q, 24'h0};
      end else if (Nk == 8 && phase_q == 3'd4) begin
         t_w = sub_word(prev_w);
      end

      if (start) begin
         for (int j = 0; j < Nk; j++) begin
            w_d[j] = key[32*j +: 32];
         end
         idx_d   = IW'(Nk);
         phase_d = 3'd0;
         rcon_d  = 8'h01;
         busy_d  = 1'b1;
         done_d  = 1'b0;
      end else if (busy_q) begin
         w_d[idx_q] = back_w ^ t_w;
         if (phase_q == 3'd0) begin
            rcon_d = xtime(rcon_q);
         end
         idx_d   = idx_q + IW'(1);
         phase_d = (phase_q == 3'(Nk - 1)) ? 3'd0 : phase_q + 3'd1;
         // final word written this cycle: schedule is complete
         if (idx_q == IW'(NW - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) begin
            w_q[i] <= '0;
         end
         idx_q   <= '0;
         phase_q <= '0;
         rcon_q  <= 8'h01;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         w_q     <= w_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         rcon_q  <= rcon_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   for (genvar g = 0; g < NW; g++) begin : g_out
      assign w[32*g +: 32] = w_q[g];
   end

   assign done = done_q;

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion: AES-128/192/256 instances,
// known-answer round keys, latency, restart and mid-run reset.
module tb_key_expansion;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               st4, st6, st8;
   logic [0:127]       k4;
   logic [0:191]       k6;
   logic [0:255]       k8;
   logic [0:32*44-1]   w4;
   logic [0:32*52-1]   w6;
   logic [0:32*60-1]   w8;
   logic               done4, done6, done8;

   key_expansion #(.Nk(4), .Nr(10)) u_k128 (
      .clk(clk), .rst(rst), .start(st4), .key(k4), .w(w4), .done(done4));
   key_expansion #(.Nk(6), .Nr(12)) u_k192 (
      .clk(clk), .rst(rst), .start(st6), .key(k6), .w(w6), .done(done6));
   key_expansion #(.Nk(8), .Nr(14)) u_k256 (
      .clk(clk), .rst(rst), .start(st8), .key(k8), .w(w8), .done(done8));

   typedef struct {
      int           dut;
      int           rnd;
      logic [127:0] val;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [0:255] KEY_SEQ =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:255] KEY_FIPS =
      {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rk(int d, int r);
      logic [127:0] v;
      v = '0;
      case (d)
         4: v = w4[128*r +: 128];
         6: v = w6[128*r +: 128];
         default: v = w8[128*r +: 128];
      endcase
      return v;
   endfunction

   function automatic logic dn(int d);
      return (d == 4) ? done4 : (d == 6) ? done6 : done8;
   endfunction

   task automatic push(int d, int r, logic [127:0] v, string tag);
      exp_t e;
      e.dut = d; e.rnd = r; e.val = v; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic pulse(int d, logic [0:255] kk);
      @(negedge clk);
      case (d)
         4: begin st4 = 1'b1; k4 = kk[0:127]; end
         6: begin st6 = 1'b1; k6 = kk[0:191]; end
         default: begin st8 = 1'b1; k8 = kk; end
      endcase
      @(posedge clk);
      #1;
      st4 = 1'b0; st6 = 1'b0; st8 = 1'b0;
      // later key changes must be ignored
      k4 = ~kk[0:127]; k6 = ~kk[0:191]; k8 = ~kk;
   endtask

   task automatic drain(int d);
      exp_t e;
      while (sb.size() > 0 && sb[0].dut == d) begin
         e = sb.pop_front();
         check(e.tag, rk(d, e.rnd), e.val);
      end
   endtask

   task automatic run(int d, logic [0:255] kk, int lat);
      int n;
      bit hit;
      n = 0;
      hit = 1'b0;
      pulse(d, kk);
      while (!hit && n < lat + 10) begin
         @(posedge clk);
         #1;
         n++;
         if (dn(d)) hit = 1'b1;
      end
      check($sformatf("latency%0d", d), 128'(n), 128'(lat));
      drain(d);
   endtask

   initial begin
      bit seen;
      logic [127:0] r10;
      rst = 1'b1;
      st4 = 1'b0; st6 = 1'b0; st8 = 1'b0;
      k4 = '0; k6 = '0; k8 = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_w", 128'(|{w4, w6, w8}), 128'h0);
      check("rst_done", 128'({done4, done6, done8}), 128'h0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (100) begin
         @(posedge clk);
         #1;
         seen |= done4 | done6 | done8;
      end
      check("idle_done", 128'(seen), 128'h0);

      push(4, 0, 128'h000102030405060708090a0b0c0d0e0f, "k128_r0");
      push(4, 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "k128_r1");
      push(4, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "k128_r10");
      run(4, KEY_SEQ, 40);

      r10 = rk(4, 10);
      repeat (5) @(posedge clk);
      #1;
      check("hold_done", 128'(done4), 128'h1);
      check("hold_w", rk(4, 10), r10);

      push(4, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_r0");
      push(4, 1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_r1");
      push(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_r10");
      run(4, KEY_FIPS, 40);

      push(6, 0, 128'h000102030405060708090a0b0c0d0e0f, "k192_r0");
      push(6, 12, 128'ha4970a331a78dc09c418c271e3a41d5d, "k192_r12");
      run(6, KEY_SEQ, 46);

      push(8, 0, 128'h000102030405060708090a0b0c0d0e0f, "k256_r0");
      push(8, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "k256_r14");
      run(8, KEY_SEQ, 52);

      pulse(4, KEY_SEQ);
      repeat (19) @(posedge clk);
      #1;
      check("restart_early", 128'(done4), 128'h0);
      push(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_r10");
      push(4, 1, 128'ha0fafe1788542cb123a339392a6c7605, "restart_r1");
      run(4, KEY_FIPS, 40);

      pulse(4, KEY_SEQ);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_w", 128'(|w4), 128'h0);
      check("midrst_done", 128'(done4), 128'h0);
      seen = 1'b0;
      repeat (60) begin
         @(posedge clk);
         #1;
         seen |= done4;
      end
      check("midrst_nodone", 128'(seen), 128'h0);
      check("sb_empty", 128'(sb.size()), 128'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
